// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, iteration count and the operand magnitude helper.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// 64-bit accumulator with a 33-bit adder/subtractor; one shift-add multiply
// step or one restoring-division step per enabled cycle.
module mdu_shift_core (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_en,
  input  logic        i_div,
  input  logic [63:0] i_load_val,
  input  logic [31:0] i_operand,
  output logic [63:0] o_acc
);

  logic [63:0] r_acc;
  logic [63:0] w_next;
  logic [32:0] w_add;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_add    = {1'b0, r_acc[63:32]} + {1'b0, i_operand};
    w_rem_sh = r_acc[63:31];
    w_diff   = w_rem_sh - {1'b0, i_operand};
    w_next   = r_acc;
    if (i_div) begin
      if (w_diff[32]) begin
        w_next = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
      end else begin
        w_next = {w_diff[31:0], r_acc[30:0], 1'b1};
      end
    end else begin
      if (r_acc[0]) begin
        w_next = {w_add, r_acc[31:1]};
      end else begin
        w_next = {1'b0, r_acc[63:1]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= 64'd0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO result registers and
// idle-time move-to writes; 33 cycles from start to done.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  mdu_state_t r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_sign_a, r_sign_b, r_b_zero;
  logic [31:0] r_opnd, r_src_a;
  logic [31:0] r_hi, r_lo;
  logic        r_busy, r_done;

  logic        w_load, w_signed_in, w_signed, w_neg;
  logic [31:0] w_mag_a, w_mag_b, w_quot, w_rem, w_res_hi, w_res_lo;
  logic [63:0] w_acc, w_prod;

  assign w_signed_in = ~i_op[0];
  assign w_mag_a     = mdu_abs(i_src_a, w_signed_in);
  assign w_mag_b     = mdu_abs(i_src_b, w_signed_in);
  assign w_load      = (r_state == IDLE) && i_start;

  mdu_shift_core u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_en       (r_state == RUN),
    .i_div      (r_op[1]),
    .i_load_val (i_op[1] ? {32'd0, w_mag_a} : {32'd0, w_mag_b}),
    .i_operand  (r_opnd),
    .o_acc      (w_acc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = i_start ? RUN : IDLE;
      RUN:     w_state_nxt = (r_cnt == 5'(MDU_ITER - 1)) ? FIX : RUN;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign fix-up; a zero divisor bypasses the datapath so hi keeps the raw dividend.
  always_comb begin
    w_signed = ~r_op[0];
    w_neg    = w_signed & (r_sign_a ^ r_sign_b);
    w_prod   = w_neg ? (64'd0 - w_acc) : w_acc;
    w_quot   = w_neg ? (32'd0 - w_acc[31:0]) : w_acc[31:0];
    w_rem    = (w_signed && r_sign_a) ? (32'd0 - w_acc[63:32]) : w_acc[63:32];
    if (!r_op[1]) begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end else if (r_b_zero) begin
      w_res_hi = r_src_a;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == RUN) ? r_cnt + 5'd1 : 5'd0;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (r_state == FIX);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op     <= 2'b00;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= 32'd0;
      r_src_a  <= 32'd0;
    end else if (w_load) begin
      r_op     <= i_op;
      r_sign_a <= w_signed_in & i_src_a[31];
      r_sign_b <= w_signed_in & i_src_b[31];
      r_b_zero <= (i_src_b == 32'd0);
      r_opnd   <= i_op[1] ? w_mag_b : w_mag_a;
      r_src_a  <= i_src_a;
    end
  end

  // A start in the same idle cycle takes priority over move-to writes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if ((r_state == IDLE) && !i_start) begin
      if (i_wr_hi) r_hi <= i_wr_data;
      if (i_wr_lo) r_lo <= i_wr_data;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
